// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped 8N1 transmitter: register map,
// STATUS/CTRL bit positions, transmit FSM states and the reset divisor.
package uart_tx_pkg;

  localparam logic [2:0] ADDR_THR_STAT = 3'd0;
  localparam logic [2:0] ADDR_DIVL     = 3'd1;
  localparam logic [2:0] ADDR_DIVH     = 3'd2;
  localparam logic [2:0] ADDR_CTRL     = 3'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_IDLE    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IEN   = 1;
  localparam int CTRL_FLUSH = 7;

  // 50 MHz / 115200 baud
  localparam logic [15:0] TX_DEFAULT_DIV = 16'd434;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output, synchronous flush,
// and push+pop allowed in the same cycle even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 serial transmitter: CPU pushes bytes into a FIFO and the
// FSM serialises them LSB first at a programmable bit period of DIV clocks.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = TX_DEFAULT_DIV,
  localparam int         CW          = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [2:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       sout,
  output logic       tx_intr
);

  logic          wr, rd, wr_q, rd_stat_q, wr_pulse;
  logic          push, pop, flush;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [15:0]   div, reload;
  logic          en, ien, overflow, idle;

  tx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        sout_n;

  assign wr       = ~cs_n & ~wr_n;
  assign rd       = ~cs_n & ~rd_n;
  assign wr_pulse = wr & ~wr_q;
  assign push     = wr_pulse && (addr == ADDR_THR_STAT);
  assign flush    = wr_pulse && (addr == ADDR_CTRL) && wr_data[CTRL_FLUSH];
  assign idle     = fifo_empty && (state == ST_IDLE);
  // DIV=0 behaves as a one-cycle bit.
  assign reload   = (div == 16'd0) ? 16'd0 : div - 16'd1;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (wr_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= 1'b0;
      rd_stat_q <= 1'b0;
      div       <= DEFAULT_DIV;
      en        <= 1'b1;
      ien       <= 1'b0;
      overflow  <= 1'b0;
      tx_intr   <= 1'b0;
    end else begin
      wr_q      <= wr;
      rd_stat_q <= rd && (addr == ADDR_THR_STAT);
      tx_intr   <= ien & fifo_empty;
      if (wr_pulse) begin
        unique case (addr)
          ADDR_DIVL: div[7:0]  <= wr_data;
          ADDR_DIVH: div[15:8] <= wr_data;
          ADDR_CTRL: begin
            en  <= wr_data[CTRL_EN];
            ien <= wr_data[CTRL_IEN];
          end
          default: ;
        endcase
      end
      // Sticky until the CPU finishes a STATUS read (falling edge of rd).
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (rd_stat_q && !rd)     overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (addr)
      ADDR_THR_STAT: begin
        rd_data[STAT_EMPTY]                 = fifo_empty;
        rd_data[STAT_FULL]                  = fifo_full;
        rd_data[STAT_IDLE]                  = idle;
        rd_data[STAT_OVF]                   = overflow;
        rd_data[STAT_CNT_LSB +: 4]          = 4'(fifo_count);
      end
      ADDR_DIVL: rd_data = div[7:0];
      ADDR_DIVH: rd_data = div[15:8];
      ADDR_CTRL: begin
        rd_data[CTRL_EN]  = en;
        rd_data[CTRL_IEN] = ien;
      end
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      sout    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      sout    <= sout_n;
    end
  end

  // Each state holds for reload+1 cycles; the line level is registered so it
  // changes on the clock after the decision.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    sout_n    = sout;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_dout;
          cnt_n   = reload;
          sout_n  = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (cnt == 16'd0) begin
          cnt_n     = reload;
          sout_n    = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = 3'd0;
          state_n   = ST_DATA;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt == 16'd0) begin
          cnt_n = reload;
          if (bit_idx == 3'd7) begin
            sout_n  = 1'b1;
            state_n = ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            sout_n    = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt == 16'd0) begin
          if (en && !fifo_empty) begin
            pop     = 1'b1;
            shreg_n = fifo_dout;
            cnt_n   = reload;
            sout_n  = 1'b0;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed register/timing scenarios plus
// randomized bursts decoded by a line-level receiver model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       sout;
  logic       tx_intr;

  int n_err = 0;
  int n_chk = 0;

  logic wave  [0:511];
  logic iwave [0:511];

  bit       mon_en = 1'b0;
  int       mon_b  = 1;
  bit [7:0] rx_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .rd_n    (rd_n),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .sout    (sout),
    .tx_intr (tx_intr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d, input int hold);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; wr_data = d;
    repeat (hold) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
    cs_n = 1'b0; rd_n = 1'b0; addr = a;
    @(negedge clk);
    v = rd_data;
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      wave[k]  = sout;
      iwave[k] = tx_intr;
    end
  endtask

  // Ideal 8N1 line levels, one entry per clock: start, 8 data LSB first, stop.
  function automatic logic [127:0] frame_wave(input logic [7:0] b, input int bl);
    logic [127:0] v;
    int pos;
    v = '0;
    for (int k = 0; k < 10 * bl; k++) begin
      pos = k / bl;
      if (pos == 0)      v[k] = 1'b0;
      else if (pos == 9) v[k] = 1'b1;
      else               v[k] = b[pos-1];
    end
    return v;
  endfunction

  function automatic logic [127:0] pick(input int from, input int len);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = wave[from+i];
    return v;
  endfunction

  function automatic logic [127:0] ones(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Receiver model: on a low line, collect a whole frame and decode it.
  initial begin
    logic [127:0] f;
    logic [7:0]   b;
    forever begin
      @(negedge clk);
      if (mon_en && sout === 1'b0) begin
        f = '0;
        for (int i = 1; i < 10 * mon_b; i++) begin
          @(negedge clk);
          f[i] = sout;
        end
        for (int i = 0; i < 8; i++) b[i] = f[(i + 1) * mon_b];
        check("rx_frame_shape", f, frame_wave(b, mon_b));
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic [7:0] ob [9];
    logic [7:0] fb [5];
    bit [7:0]   exp_q [$];
    logic [7:0] d, b;
    int         n, hold;
    bit         done;

    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_sout", sout, 1'b1);
    check("rst_intr", tx_intr, 1'b0);
    rd_reg(3'd0, v); check("rst_status", v, 8'h05);
    rd_reg(3'd1, v); check("rst_divl", v, 8'hB2);
    rd_reg(3'd2, v); check("rst_divh", v, 8'h01);
    rd_reg(3'd3, v); check("rst_ctrl", v, 8'h01);
    rd_reg(3'd6, v); check("rst_unmapped", v, 8'h00);

    // Single frame, DIV=4
    wr_reg(3'd1, 8'd4, 1);
    wr_reg(3'd2, 8'd0, 1);
    rd_reg(3'd1, v); check("div_readback", v, 8'd4);
    fork
      wr_reg(3'd0, 8'hA5, 1);
      capture(42);
    join
    check("a5_pre_start", wave[1], 1'b1);
    check("a5_frame", pick(2, 40), frame_wave(8'hA5, 4));
    check("a5_after", wave[42], 1'b1);
    rd_reg(3'd0, v); check("a5_status_idle", v, 8'h05);

    // Three writes, strobe held 5 cycles each: contiguous frames
    fork
      begin
        wr_reg(3'd0, 8'h01, 5);
        wr_reg(3'd0, 8'h02, 5);
        wr_reg(3'd0, 8'h03, 5);
      end
      capture(122);
    join
    check("b2b_pre", wave[1], 1'b1);
    for (int f = 0; f < 3; f++)
      check($sformatf("b2b_frame%0d", f), pick(2 + 40 * f, 40), frame_wave(8'(f + 1), 4));
    check("b2b_after", wave[122], 1'b1);
    rd_reg(3'd0, v); check("b2b_status", v, 8'h05);

    // Overflow with transmitter disabled
    wr_reg(3'd3, 8'h00, 1);
    for (int i = 0; i < 9; i++) begin
      ob[i] = 8'($urandom);
      wr_reg(3'd0, ob[i], 1);
    end
    rd_reg(3'd0, v); check("ovf_status", v, 8'h8A);
    rd_reg(3'd0, v); check("ovf_cleared", v, 8'h82);
    fork
      wr_reg(3'd3, 8'h01, 1);
      capture(330);
    join
    for (int f = 0; f < 8; f++)
      check($sformatf("ovf_frame%0d", f), pick(2 + 40 * f, 40), frame_wave(ob[f], 4));
    check("ovf_ninth_dropped", pick(322, 9), ones(9));
    rd_reg(3'd0, v); check("ovf_final_status", v, 8'h05);

    // Interrupt
    fork
      wr_reg(3'd3, 8'h03, 1);
      capture(3);
    join
    check("intr_reg_delay", iwave[1], 1'b0);
    check("intr_on", iwave[2], 1'b1);
    fork
      wr_reg(3'd0, 8'h5A, 1);
      capture(44);
    join
    check("intr_before_push", iwave[1], 1'b1);
    check("intr_after_push", iwave[2], 1'b0);
    check("intr_after_pop", iwave[3], 1'b1);
    check("intr_frame", pick(2, 40), frame_wave(8'h5A, 4));
    wr_reg(3'd3, 8'h01, 1);

    // Flush mid-DATA with 4 bytes queued
    for (int i = 0; i < 5; i++) fb[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 5; i++) wr_reg(3'd0, fb[i], 1);
        repeat (6) @(negedge clk);
        rd_reg(3'd0, v); check("flush_pre_count", v, 8'h40);
        wr_reg(3'd3, 8'h81, 1);
        rd_reg(3'd0, v); check("flush_status", v, 8'h01);
      end
      capture(70);
    join
    check("flush_frame_completes", pick(2, 40), frame_wave(fb[0], 4));
    check("flush_line_stays_high", pick(42, 29), ones(29));
    rd_reg(3'd3, v); check("flush_reads_zero", v, 8'h01);
    rd_reg(3'd0, v); check("flush_final_status", v, 8'h05);

    // Asynchronous reset mid-frame
    fork
      wr_reg(3'd0, 8'h00, 1);
      capture(3);
    join
    check("arst_in_start", wave[3], 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sout_async", sout, 1'b1);
    check("arst_status_async", rd_data, 8'h05);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_intr", tx_intr, 1'b0);
    rd_reg(3'd1, v); check("arst_divl", v, 8'hB2);
    capture(50);
    check("arst_no_resume", pick(1, 50), ones(50));

    // Randomized bursts checked by the receiver model
    mon_en = 1'b1;
    for (int burst = 0; burst < 6; burst++) begin
      d = 8'($urandom_range(0, 6));
      wr_reg(3'd1, d, 1);
      wr_reg(3'd2, 8'h00, 1);
      mon_b = (d == 8'd0) ? 1 : int'(d);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        hold = $urandom_range(1, 3);
        wr_reg(3'd0, b, hold);
        exp_q.push_back(b);
      end
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
        rd_reg(3'd0, v);
        if (v[2]) done = 1'b1;
      end
      check($sformatf("burst%0d_idle", burst), done, 1'b1);
      repeat (2) @(negedge clk);
      check($sformatf("burst%0d_count", burst), rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
        check($sformatf("burst%0d_byte%0d", burst, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
